// File: rtl/iter_alu_if.sv
// Command/result bus for iter_alu: operand handshake in, result handshake out.
interface iter_alu_if #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [2:0]           op_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] alu_out;
    logic                 carry;
    logic                 zero;
    logic                 div_err;

    // Producer of commands and consumer of results
    modport master (
        output in_valid, a_in, b_in, op_in, out_ready,
        input  in_ready, out_valid, alu_out, carry, zero, div_err
    );

    // The ALU itself
    modport slave (
        input  in_valid, a_in, b_in, op_in, out_ready,
        output in_ready, out_valid, alu_out, carry, zero, div_err
    );
endinterface

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle ADD/SUB/MULT/logic ops, WIDTH-cycle restoring
// divider. One command in flight; result held until the consumer takes it.
module iter_alu #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic      clk,
    input  logic      rst,      // asynchronous, active-low
    iter_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] alu_out_q, alu_out_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 div_err_q, div_err_d;
    logic [WIDTH-1:0]     rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0]     quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 accept_s;
    logic                 div_start_s;
    logic [WIDTH:0]       sum_s;
    logic [OUT_WIDTH-1:0] op_res_s;
    logic                 op_carry_s;
    logic                 op_err_s;
    logic [WIDTH:0]       trial_s;
    logic [WIDTH-1:0]     rem_step_s;
    logic [WIDTH-1:0]     quo_step_s;

    assign accept_s    = bus.in_valid && (state_q == IDLE);
    assign div_start_s = (bus.op_in == OP_DIV) && (bus.b_in != {WIDTH{1'b0}});

    // Single-cycle result for the operands currently on the bus
    always_comb begin
        sum_s      = {1'b0, bus.a_in} + {1'b0, bus.b_in};
        op_res_s   = {OUT_WIDTH{1'b0}};
        op_carry_s = 1'b0;
        op_err_s   = 1'b0;
        case (bus.op_in)
            OP_ADD: begin
                op_res_s   = {{(WIDTH-1){1'b0}}, sum_s};
                op_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                // extend before subtracting so the wrap is at OUT_WIDTH bits
                op_res_s   = {{WIDTH{1'b0}}, bus.a_in} - {{WIDTH{1'b0}}, bus.b_in};
                op_carry_s = (bus.a_in < bus.b_in);
            end
            OP_MULT: op_res_s = {{WIDTH{1'b0}}, bus.a_in} * {{WIDTH{1'b0}}, bus.b_in};
            OP_DIV: begin
                // only reaches the result register when the divisor is zero
                op_res_s = {bus.a_in, {WIDTH{1'b1}}};
                op_err_s = 1'b1;
            end
            OP_AND:  op_res_s = {{WIDTH{1'b0}}, bus.a_in & bus.b_in};
            OP_OR:   op_res_s = {{WIDTH{1'b0}}, bus.a_in | bus.b_in};
            OP_NOT:  op_res_s = {{WIDTH{1'b0}}, ~bus.a_in};
            OP_XOR:  op_res_s = {{WIDTH{1'b0}}, bus.a_in ^ bus.b_in};
            default: op_res_s = {OUT_WIDTH{1'b0}};
        endcase
    end

    // One restoring-division step: try subtracting the divisor from the shifted remainder
    always_comb begin
        trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};
        if (trial_s[WIDTH]) begin
            rem_step_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_step_s = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
            quo_step_s = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and result-register logic
    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        div_err_d = div_err_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s && div_start_s) begin
                    state_d   = DIV_RUN;
                    rem_d     = {WIDTH{1'b0}};
                    quo_d     = bus.a_in;
                    divisor_d = bus.b_in;
                    cnt_d     = CNT_W'(WIDTH - 1);
                end else if (accept_s) begin
                    state_d   = DONE;
                    alu_out_d = op_res_s;
                    carry_d   = op_carry_s;
                    zero_d    = (op_res_s == {OUT_WIDTH{1'b0}});
                    div_err_d = op_err_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DIV_RUN: begin
                rem_d = rem_step_s;
                quo_d = quo_step_s;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d   = DONE;
                    alu_out_d = {rem_step_s, quo_step_s};
                    carry_d   = 1'b0;
                    zero_d    = ({rem_step_s, quo_step_s} == {OUT_WIDTH{1'b0}});
                    div_err_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any command in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            alu_out_q <= {OUT_WIDTH{1'b0}};
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            div_err_q <= 1'b0;
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            div_err_q <= div_err_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.alu_out   = alu_out_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.div_err   = div_err_q;
endmodule
